// File: rtl/jstk_spi_reader.sv
// SPI mode-0 master that polls a PmodJSTK joystick. Every POLL_PERIOD cycles it
// runs one 5-byte transaction and sends the LED command in byte 0. It assembles
// the 10-bit X/Y positions and 3 button bits, then publishes all of them together
// with a one-cycle data_valid pulse.
//
//  state   | meaning
//  IDLE    | ss high, poll timer running, waiting for en and timer expiry
//  SS_WAIT | ss low, setup time before the first SCLK low half
//  SHIFT   | clocking one byte, 8 bits MSB first, low half then high half
//  GAP     | SCLK held low between bytes 0-3 and the next byte
//  HOLD    | SCLK low for one half period after byte 4, before ss rises
//  DONE    | ss high, outputs loaded from shadow regs, data_valid asserted
module jstk_spi_reader #(
  parameter int CLK_DIV     = 50,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] leds,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       ss,
  output logic [9:0] jstkPosX,
  output logic [9:0] jstkPosY,
  output logic [2:0] buttons,
  output logic       data_valid,
  output logic       busy
);

  localparam int CNT_MAX0 = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int CNT_MAX  = (CNT_MAX0 > CLK_DIV) ? CNT_MAX0 : CLK_DIV;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int TW       = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [CW-1:0] LD_SETUP  = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] LD_HALF   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LD_GAP    = CW'(BYTE_GAP - 1);
  localparam logic [TW-1:0] POLL_LAST = TW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SS_WAIT, SHIFT, GAP, HOLD, DONE} state_t;

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic [CW-1:0] cnt;
  logic          tc, start, samp, low_start;
  logic [2:0]    bit_idx, byte_idx;
  logic [7:0]    tx_sr;
  logic [6:0]    rx_sr;
  logic [7:0]    rx_byte;
  logic          miso_s1, miso_s2;
  logic [7:0]    x_lo, y_lo;
  logic [1:0]    x_hi, y_hi;
  logic [2:0]    btn_sh;

  assign tc        = (cnt == '0);
  assign start     = (state == IDLE) && en && (timer >= POLL_LAST);
  // The sample point is the last clk of a high half, which is also where sclk falls.
  assign samp      = (state == SHIFT) && tc && sclk;
  assign low_start = ((state == SS_WAIT || state == GAP) && tc) || (samp && bit_idx != 3'd7);
  assign rx_byte   = {rx_sr, miso_s2};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SS_WAIT;
      SS_WAIT: if (tc) next_state = SHIFT;
      SHIFT:   if (samp && bit_idx == 3'd7) next_state = (byte_idx == 3'd4) ? HOLD : GAP;
      GAP:     if (tc) next_state = SHIFT;
      HOLD:    if (tc) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy       = (state != IDLE);
    data_valid = (state == DONE);
  end

  // Poll timer: counts up from each start and saturates so a late transaction restarts at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    timer <= '0;
    else if (start)             timer <= '0;
    else if (timer < POLL_LAST) timer <= timer + 1'b1;
  end

  // Phase down-counter, reloaded with the length of whichever phase comes next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LD_SETUP;
    end else if (state != IDLE && tc) begin
      case (next_state)
        SHIFT:   cnt <= LD_HALF;
        GAP:     cnt <= LD_GAP;
        HOLD:    cnt <= LD_HALF;
        default: cnt <= '0;
      endcase
    end else if (!tc) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Two-flop synchroniser for miso
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= miso;
      miso_s2 <= miso_s1;
    end
  end

  // SPI pins and shift registers. Registered so that ss/sclk/mosi cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      ss <= !(next_state inside {SS_WAIT, SHIFT, GAP, HOLD});
      if (state == SHIFT && tc) sclk <= ~sclk;
      else if (state != SHIFT)  sclk <= 1'b0;
      if (start) begin
        // leds are captured here, so a change mid-transaction waits for the next poll
        tx_sr    <= {6'b100000, leds};
        bit_idx  <= '0;
        byte_idx <= '0;
      end
      if (low_start) begin
        mosi  <= tx_sr[7];
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
      if (samp) begin
        rx_sr   <= rx_byte[6:0];
        bit_idx <= bit_idx + 3'd1;
        if (bit_idx == 3'd7) byte_idx <= byte_idx + 3'd1;
      end
    end
  end

  // Shadow capture per byte, then an atomic publish on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_lo     <= '0;
      x_hi     <= '0;
      y_lo     <= '0;
      y_hi     <= '0;
      btn_sh   <= '0;
      jstkPosX <= 10'd512;
      jstkPosY <= 10'd512;
      buttons  <= '0;
    end else begin
      if (samp && bit_idx == 3'd7) begin
        case (byte_idx)
          3'd0:    x_lo   <= rx_byte;
          3'd1:    x_hi   <= rx_byte[1:0];
          3'd2:    y_lo   <= rx_byte;
          3'd3:    y_hi   <= rx_byte[1:0];
          3'd4:    btn_sh <= rx_byte[2:0];
          default: ;
        endcase
      end
      if (state == HOLD && tc) begin
        jstkPosX <= {x_hi, x_lo};
        jstkPosY <= {y_hi, y_lo};
        buttons  <= btn_sh;
      end
    end
  end

endmodule
